// File: rtl/ex_mem_wb_pipe_if.sv
// Interface bundling the EX/MEM/WB pipeline data, hazard-unit and data-memory signals.
// master: the core side that drives EX and memory data. slave: the pipeline register block.
interface ex_mem_wb_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
);
  logic              stall_m;
  logic              flush_m;
  logic              valid_ex;
  logic              regwrite_ex;
  logic              memtoreg_ex;
  logic              memwrite_ex;
  logic [DATA_W-1:0] aluout_ex;
  logic [DATA_W-1:0] writedata_ex;
  logic [REG_W-1:0]  writereg_ex;

  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;

  logic              regwrite_mem;
  logic [REG_W-1:0]  writereg_mem;
  logic [DATA_W-1:0] aluout_mem;
  logic              regwrite_wb;
  logic [REG_W-1:0]  writereg_wb;
  logic [DATA_W-1:0] result_wb;
  logic [31:0]       instret;

  modport master (
    output stall_m, flush_m, valid_ex, regwrite_ex, memtoreg_ex, memwrite_ex,
    output aluout_ex, writedata_ex, writereg_ex, dmem_rdata,
    input  dmem_we, dmem_addr, dmem_wdata,
    input  regwrite_mem, writereg_mem, aluout_mem,
    input  regwrite_wb, writereg_wb, result_wb, instret
  );

  modport slave (
    input  stall_m, flush_m, valid_ex, regwrite_ex, memtoreg_ex, memwrite_ex,
    input  aluout_ex, writedata_ex, writereg_ex, dmem_rdata,
    output dmem_we, dmem_addr, dmem_wdata,
    output regwrite_mem, writereg_mem, aluout_mem,
    output regwrite_wb, writereg_wb, result_wb, instret
  );
endinterface

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core, with data-memory
// drive, register-file write port, hazard-unit taps and a retired-instruction counter.
module ex_mem_wb_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input logic              clk,
  input logic              reset,
  ex_mem_wb_pipe_if.slave  bus
);

  // EX/MEM state
  logic              valid_mem_q, valid_mem_d;
  logic              regwrite_mem_q, regwrite_mem_d;
  logic              memtoreg_mem_q, memtoreg_mem_d;
  logic              memwrite_mem_q, memwrite_mem_d;
  logic [DATA_W-1:0] aluout_mem_q, aluout_mem_d;
  logic [DATA_W-1:0] writedata_mem_q, writedata_mem_d;
  logic [REG_W-1:0]  writereg_mem_q, writereg_mem_d;

  // MEM/WB state
  logic              valid_wb_q, valid_wb_d;
  logic              regwrite_wb_q, regwrite_wb_d;
  logic [REG_W-1:0]  writereg_wb_q, writereg_wb_d;
  logic [DATA_W-1:0] result_wb_q, result_wb_d;
  logic [31:0]       instret_q, instret_d;

  always_comb begin
    valid_mem_d     = valid_mem_q;
    regwrite_mem_d  = regwrite_mem_q;
    memtoreg_mem_d  = memtoreg_mem_q;
    memwrite_mem_d  = memwrite_mem_q;
    aluout_mem_d    = aluout_mem_q;
    writedata_mem_d = writedata_mem_q;
    writereg_mem_d  = writereg_mem_q;

    if (bus.flush_m) begin
      valid_mem_d     = 1'b0;
      regwrite_mem_d  = 1'b0;
      memtoreg_mem_d  = 1'b0;
      memwrite_mem_d  = 1'b0;
      aluout_mem_d    = '0;
      writedata_mem_d = '0;
      writereg_mem_d  = '0;
    end else if (!bus.stall_m) begin
      valid_mem_d     = bus.valid_ex;
      // Register $0 is hardwired, so a write to it is dropped here.
      regwrite_mem_d  = bus.regwrite_ex & bus.valid_ex & (bus.writereg_ex != '0);
      memtoreg_mem_d  = bus.memtoreg_ex;
      memwrite_mem_d  = bus.memwrite_ex;
      aluout_mem_d    = bus.aluout_ex;
      writedata_mem_d = bus.writedata_ex;
      writereg_mem_d  = bus.writereg_ex;
    end
  end

  always_comb begin
    valid_wb_d    = valid_mem_q;
    regwrite_wb_d = regwrite_mem_q;
    writereg_wb_d = writereg_mem_q;
    result_wb_d   = memtoreg_mem_q ? bus.dmem_rdata : aluout_mem_q;

    // A held MEM instruction must retire only once, so WB sees bubbles until release.
    if (bus.stall_m) begin
      valid_wb_d    = 1'b0;
      regwrite_wb_d = 1'b0;
      writereg_wb_d = writereg_wb_q;
      result_wb_d   = result_wb_q;
    end

    instret_d = instret_q + 32'(valid_wb_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_mem_q     <= 1'b0;
      regwrite_mem_q  <= 1'b0;
      memtoreg_mem_q  <= 1'b0;
      memwrite_mem_q  <= 1'b0;
      aluout_mem_q    <= '0;
      writedata_mem_q <= '0;
      writereg_mem_q  <= '0;
      valid_wb_q      <= 1'b0;
      regwrite_wb_q   <= 1'b0;
      writereg_wb_q   <= '0;
      result_wb_q     <= '0;
      instret_q       <= '0;
    end else begin
      valid_mem_q     <= valid_mem_d;
      regwrite_mem_q  <= regwrite_mem_d;
      memtoreg_mem_q  <= memtoreg_mem_d;
      memwrite_mem_q  <= memwrite_mem_d;
      aluout_mem_q    <= aluout_mem_d;
      writedata_mem_q <= writedata_mem_d;
      writereg_mem_q  <= writereg_mem_d;
      valid_wb_q      <= valid_wb_d;
      regwrite_wb_q   <= regwrite_wb_d;
      writereg_wb_q   <= writereg_wb_d;
      result_wb_q     <= result_wb_d;
      instret_q       <= instret_d;
    end
  end

  // A stalled store writes only on its release cycle; never write while reset is applied.
  assign bus.dmem_we      = memwrite_mem_q & valid_mem_q & ~bus.stall_m & ~reset;
  assign bus.dmem_addr    = aluout_mem_q;
  assign bus.dmem_wdata   = writedata_mem_q;
  assign bus.regwrite_mem = regwrite_mem_q;
  assign bus.writereg_mem = writereg_mem_q;
  assign bus.aluout_mem   = aluout_mem_q;
  assign bus.regwrite_wb  = regwrite_wb_q;
  assign bus.writereg_wb  = writereg_wb_q;
  assign bus.result_wb    = result_wb_q;
  assign bus.instret      = instret_q;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Directed bench for ex_mem_wb_pipe: WB results are queued when an instruction is
// issued and popped when it reaches WB; other outputs are checked against constants.
module tb_ex_mem_wb_pipe;

  logic clk;
  logic reset;

  ex_mem_wb_pipe_if #(.DATA_W(32), .REG_W(5)) bus ();

  ex_mem_wb_pipe #(.DATA_W(32), .REG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: one known word, everything else reads as the inverted address.
  assign bus.dmem_rdata = (bus.dmem_addr == 32'h100) ? 32'hCAFE_0001 : ~bus.dmem_addr;

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] res;
  } wb_t;

  wb_t sb[$];
  int  checks = 0;
  int  errors = 0;
  logic [31:0] exp_instret = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_wb(input logic rw, input logic [4:0] wr, input logic [31:0] res);
    wb_t e;
    e.rw = rw; e.wr = wr; e.res = res;
    sb.push_back(e);
  endtask

  task automatic check_wb(input string tag);
    wb_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_regwrite_wb"}, 32'(bus.regwrite_wb), 32'(e.rw));
      chk({tag, "_writereg_wb"}, 32'(bus.writereg_wb), 32'(e.wr));
      chk({tag, "_result_wb"},   bus.result_wb, e.res);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    bus.valid_ex     = 1'b0;
    bus.regwrite_ex  = 1'b0;
    bus.memtoreg_ex  = 1'b0;
    bus.memwrite_ex  = 1'b0;
    bus.aluout_ex    = '0;
    bus.writedata_ex = '0;
    bus.writereg_ex  = '0;
  endtask

  task automatic issue(input logic rw, input logic m2r, input logic mw, input logic [4:0] wr,
                       input logic [31:0] alu, input logic [31:0] wd);
    bus.valid_ex     = 1'b1;
    bus.regwrite_ex  = rw;
    bus.memtoreg_ex  = m2r;
    bus.memwrite_ex  = mw;
    bus.writereg_ex  = wr;
    bus.aluout_ex    = alu;
    bus.writedata_ex = wd;
  endtask

  initial begin
    reset = 1'b1;
    bus.stall_m = 1'b0;
    bus.flush_m = 1'b0;
    idle_ex();
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_dmem_we",      32'(bus.dmem_we), 0);
    chk("rst_dmem_addr",    bus.dmem_addr, 0);
    chk("rst_regwrite_mem", 32'(bus.regwrite_mem), 0);
    chk("rst_regwrite_wb",  32'(bus.regwrite_wb), 0);
    chk("rst_result_wb",    bus.result_wb, 0);
    chk("rst_instret",      bus.instret, 0);

    // ALU chain: add r3 = 0x5
    issue(1'b1, 1'b0, 1'b0, 5'd3, 32'h5, 32'h0);
    push_wb(1'b1, 5'd3, 32'h5);
    step();
    idle_ex();
    chk("alu_regwrite_mem", 32'(bus.regwrite_mem), 1);
    chk("alu_writereg_mem", 32'(bus.writereg_mem), 3);
    chk("alu_aluout_mem",   bus.aluout_mem, 32'h5);
    step();
    check_wb("alu");
    chk("alu_instret_pre", bus.instret, exp_instret);
    step();
    exp_instret++;
    chk("alu_instret", bus.instret, exp_instret);

    // Load r4 from 0x100
    issue(1'b1, 1'b1, 1'b0, 5'd4, 32'h100, 32'h0);
    push_wb(1'b1, 5'd4, 32'hCAFE_0001);
    step();
    idle_ex();
    #1;
    chk("ld_dmem_addr", bus.dmem_addr, 32'h100);
    chk("ld_dmem_we",   32'(bus.dmem_we), 0);
    step();
    check_wb("ld");
    step();
    exp_instret++;
    chk("ld_instret", bus.instret, exp_instret);

    // Write to $0 is suppressed but still retires
    issue(1'b1, 1'b0, 1'b0, 5'd0, 32'h1234, 32'h0);
    push_wb(1'b0, 5'd0, 32'h1234);
    step();
    idle_ex();
    chk("r0_regwrite_mem", 32'(bus.regwrite_mem), 0);
    step();
    check_wb("r0");
    step();
    exp_instret++;
    chk("r0_instret", bus.instret, exp_instret);

    // Store held by a 3-cycle stall: one write on release, one retire
    issue(1'b0, 1'b0, 1'b1, 5'd0, 32'h200, 32'hDEAD_BEEF);
    push_wb(1'b0, 5'd0, 32'h200);
    step();
    idle_ex();
    bus.stall_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("st_stall%0d_we", i), 32'(bus.dmem_we), 0);
      step();
      chk($sformatf("st_stall%0d_regwrite_wb", i), 32'(bus.regwrite_wb), 0);
      chk($sformatf("st_stall%0d_instret", i), bus.instret, exp_instret);
    end
    bus.stall_m = 1'b0;
    #1;
    chk("st_rel_we",    32'(bus.dmem_we), 1);
    chk("st_rel_addr",  bus.dmem_addr, 32'h200);
    chk("st_rel_wdata", bus.dmem_wdata, 32'hDEAD_BEEF);
    step();
    chk("st_after_we", 32'(bus.dmem_we), 0);
    check_wb("st");
    step();
    exp_instret++;
    chk("st_instret", bus.instret, exp_instret);
    step();
    chk("st_instret_once", bus.instret, exp_instret);

    // flush_m with stall_m on a regwrite instruction: never reaches WB
    issue(1'b1, 1'b0, 1'b0, 5'd7, 32'h77, 32'h0);
    bus.flush_m = 1'b1;
    bus.stall_m = 1'b1;
    step();
    idle_ex();
    bus.flush_m = 1'b0;
    bus.stall_m = 1'b0;
    chk("fl_regwrite_mem", 32'(bus.regwrite_mem), 0);
    chk("fl_regwrite_wb0", 32'(bus.regwrite_wb), 0);
    step();
    chk("fl_regwrite_wb1", 32'(bus.regwrite_wb), 0);
    step();
    chk("fl_instret", bus.instret, exp_instret);

    // instret wrap
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    exp_instret = 32'hFFFF_FFFF;
    chk("wrap_preload", bus.instret, exp_instret);
    issue(1'b1, 1'b0, 1'b0, 5'd5, 32'h55, 32'h0);
    push_wb(1'b1, 5'd5, 32'h55);
    step();
    idle_ex();
    step();
    check_wb("wrap");
    step();
    exp_instret++;
    chk("wrap_instret", bus.instret, exp_instret);

    // Reset mid-load: in-flight work discarded, no RF write
    issue(1'b1, 1'b1, 1'b0, 5'd6, 32'h100, 32'h0);
    step();
    chk("rl_regwrite_mem", 32'(bus.regwrite_mem), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_ex();
    #1;
    chk("rl_regwrite_mem0", 32'(bus.regwrite_mem), 0);
    chk("rl_regwrite_wb0",  32'(bus.regwrite_wb), 0);
    chk("rl_result_wb0",    bus.result_wb, 0);
    chk("rl_dmem_addr0",    bus.dmem_addr, 0);
    chk("rl_dmem_we0",      32'(bus.dmem_we), 0);
    chk("rl_instret0",      bus.instret, 0);
    step();
    chk("rl_regwrite_wb1", 32'(bus.regwrite_wb), 0);
    chk("rl_instret1",     bus.instret, 0);
    chk("sb_drained",      32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
